spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 115 +++++++++++
 tb/tb_spi_master.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// spi_master: mode-0 SPI master, MSB-first DATA_W-bit frames, SCLK = clk/2 or clk/4.
module spi_master #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              div_sel,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              MISO,
    output logic              SCLK,
    output logic              MOSI,
    output logic              CS_n,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done
);
    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;
    localparam int TW = $clog2(2 * DATA_W);
    state_t state_q, state_d;
    logic cnt_q, cnt_d, div_q, div_d, sclk_q, sclk_d, mosi_q, mosi_d, cs_q, cs_d;
    logic [TW-1:0] tog_q, tog_d;
    logic [DATA_W-1:0] tx_q, tx_d, rxo_q, rxo_d;
    logic [DATA_W-2:0] rx_q, rx_d;
    logic tick;
    // Half-period elapsed: H-1 equals the latched divider select.
    assign tick = cnt_q == div_q;
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        div_d = div_q;
        sclk_d = sclk_q;
        mosi_d = mosi_q;
        cs_d = cs_q;
        tog_d = tog_q;
        tx_d = tx_q;
        rx_d = rx_q;
        rxo_d = rxo_q;
        case (state_q)
            IDLE: begin
                cs_d = 1'b1;
                sclk_d = 1'b0;
                mosi_d = 1'b0;
                cnt_d = 1'b0;
                tog_d = '0;
                if (start) begin
                    state_d = SETUP;
                    tx_d = tx_data;
                    div_d = div_sel;
                    cs_d = 1'b0;
                    mosi_d = tx_data[DATA_W-1];
                end
            end
            SETUP: begin
                cnt_d = tick ? 1'b0 : cnt_q + 1'b1;
                state_d = tick ? SHIFT : SETUP;
            end
            SHIFT: begin
                cnt_d = tick ? 1'b0 : cnt_q + 1'b1;
                if (tick) begin
                    sclk_d = ~sclk_q;
                    tog_d = tog_q + 1'b1;
                    // Falling SCLK: sample MISO and present the next tx bit.
                    if (sclk_q) begin
                        rx_d = {rx_q[DATA_W-3:0], MISO};
                        if (tog_q == TW'(2 * DATA_W - 1)) begin
                            state_d = DONE;
                            cs_d = 1'b1;
                            rxo_d = {rx_q, MISO};
                        end else begin
                            tx_d = {tx_q[DATA_W-2:0], tx_q[DATA_W-1]};
                            mosi_d = tx_q[DATA_W-2];
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                mosi_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= 1'b0;
            div_q <= 1'b0;
            sclk_q <= 1'b0;
            mosi_q <= 1'b0;
            cs_q <= 1'b1;
            tog_q <= '0;
            tx_q <= '0;
            rx_q <= '0;
            rxo_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            div_q <= div_d;
            sclk_q <= sclk_d;
            mosi_q <= mosi_d;
            cs_q <= cs_d;
            tog_q <= tog_d;
            tx_q <= tx_d;
            rx_q <= rx_d;
            rxo_q <= rxo_d;
        end
    end
    assign SCLK = sclk_q;
    assign MOSI = mosi_q;
    assign CS_n = cs_q;
    assign rx_data = rxo_q;
    assign busy = state_q != IDLE;
    assign done = state_q == DONE;
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: randomized scoreboard bench for spi_master; expected frames queued at issue, checked on done.
module tb_spi_master;
    localparam int DW = 8;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, div_sel = 1'b0, MISO;
    logic [DW-1:0] tx_data = '0, rx_data;
    logic SCLK, MOSI, CS_n, busy, done;
    logic [1:0] miso_mode = 2'd0;
    int checks = 0, failures = 0, cyc = 0;
    typedef struct {
        logic [DW-1:0] tx;
        logic [DW-1:0] rx;
        int done_cyc;
        int h;
    } exp_t;
    exp_t q[$];

    spi_master #(.DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .div_sel(div_sel), .tx_data(tx_data),
        .MISO(MISO), .SCLK(SCLK), .MOSI(MOSI), .CS_n(CS_n), .rx_data(rx_data),
        .busy(busy), .done(done)
    );

    // Slave models: loopback, inverted loopback, tied high, tied low.
    assign MISO = miso_mode == 2'd0 ? MOSI : miso_mode == 2'd1 ? ~MOSI : miso_mode == 2'd2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] model_rx(input logic [DW-1:0] tx, input logic [1:0] m);
        return m == 2'd0 ? tx : m == 2'd1 ? ~tx : m == 2'd2 ? {DW{1'b1}} : {DW{1'b0}};
    endfunction

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Called at a negedge with the DUT idle; E0 is the following posedge.
    task automatic issue(input logic [DW-1:0] tx, input logic dv, input logic [1:0] m,
                         input bit push, output int e0);
        int h;
        h = dv ? 2 : 1;
        tx_data = tx;
        div_sel = dv;
        miso_mode = m;
        start = 1'b1;
        e0 = cyc + 1;
        if (push) q.push_back('{tx, model_rx(tx, m), e0 + h * (2 * DW + 1), h});
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int cs_low, rises, last_rise, pmin, pmax;
        logic sclk_p, done_p;
        logic [DW-1:0] mosi_bits;
        exp_t e;
        cs_low = 0; rises = 0; last_rise = 0; pmin = 1000; pmax = 0;
        sclk_p = 1'b0; done_p = 1'b0; mosi_bits = '0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                chk("done_single_cycle", {31'd0, done_p}, 32'd0);
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done=1 expected no done (cyc %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    chk("rx_data", {24'd0, rx_data}, {24'd0, e.rx});
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("mosi_bits", {24'd0, mosi_bits}, {24'd0, e.tx});
                    chk("sclk_rises", rises, DW);
                    chk("sclk_period_min", pmin, 2 * e.h);
                    chk("sclk_period_max", pmax, 2 * e.h);
                    chk("cs_low_cycles", cs_low, e.h * (2 * DW + 1));
                end
            end
            if (busy === 1'b0) chk("idle_outputs", {29'd0, CS_n, SCLK, MOSI}, 32'd4);
            if (CS_n !== 1'b0) begin
                cs_low = 0; rises = 0; pmin = 1000; pmax = 0; mosi_bits = '0;
            end else begin
                cs_low++;
                if (SCLK && !sclk_p) begin
                    mosi_bits = {mosi_bits[DW-2:0], MOSI};
                    if (rises > 0) begin
                        if (cyc - last_rise < pmin) pmin = cyc - last_rise;
                        if (cyc - last_rise > pmax) pmax = cyc - last_rise;
                    end
                    last_rise = cyc;
                    rises++;
                end
            end
            sclk_p = SCLK;
            done_p = done;
        end
    end

    initial begin
        int e0, h, k, busy_lo, cs_hi;
        repeat (3) @(negedge clk);
        chk("reset_cs_n", {31'd0, CS_n}, 32'd1);
        chk("reset_sclk", {31'd0, SCLK}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_rx_data", {24'd0, rx_data}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        // Loopback 0xA5 at clk/2, with an ignored start at E5 carrying 0xFF.
        issue(8'hA5, 1'b0, 2'd0, 1'b1, e0);
        wait_cyc(e0 + 4);
        start = 1'b1; tx_data = 8'hFF; div_sel = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(e0 + 18);
        // MISO high, 0x3C at clk/4.
        issue(8'h3C, 1'b1, 2'd2, 1'b1, e0);
        wait_cyc(e0 + 35);
        // Reset at E9 mid-frame aborts without done.
        issue(8'h5A, 1'b0, 2'd0, 1'b0, e0);
        wait_cyc(e0 + 8);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_cs_n", {31'd0, CS_n}, 32'd1);
        chk("abort_sclk", {31'd0, SCLK}, 32'd0);
        chk("abort_mosi", {31'd0, MOSI}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_rx_data", {24'd0, rx_data}, 32'd0);
        repeat (40) @(negedge clk);
        // Reset wins over a simultaneous start.
        rst = 1'b1; start = 1'b1; tx_data = 8'hFF;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_prio_busy", {31'd0, busy}, 32'd0);
        chk("rst_prio_cs_n", {31'd0, CS_n}, 32'd1);
        @(negedge clk);
        chk("rst_prio_busy_after", {31'd0, busy}, 32'd0);
        // Start held high: back-to-back 0x81 then 0x7E, one idle cycle between.
        miso_mode = 2'd0; div_sel = 1'b0; tx_data = 8'h81; start = 1'b1;
        e0 = cyc + 1;
        q.push_back('{8'h81, 8'h81, e0 + 17, 1});
        q.push_back('{8'h7E, 8'h7E, e0 + 19 + 17, 1});
        @(negedge clk);
        tx_data = 8'h7E;
        busy_lo = 0; cs_hi = 0;
        while (cyc < e0 + 19) begin
            if (!busy) busy_lo++;
            if (CS_n) cs_hi++;
            @(negedge clk);
        end
        start = 1'b0;
        chk("b2b_idle_gap", busy_lo, 1);
        chk("b2b_cs_high_gap_ge1", {31'd0, cs_hi >= 1}, 32'd1);
        wait_cyc(e0 + 37);
        // Randomized frames, some with spurious mid-frame start/tx/div changes.
        for (int i = 0; i < 24; i++) begin
            logic dv;
            dv = 1'($urandom_range(0, 1));
            h = dv ? 2 : 1;
            issue(DW'($urandom), dv, 2'($urandom_range(0, 3)), 1'b1, e0);
            if ($urandom_range(0, 1) == 1) begin
                k = $urandom_range(1, h * (2 * DW + 1) - 1);
                wait_cyc(e0 + k);
                start = 1'b1; tx_data = DW'($urandom); div_sel = 1'($urandom_range(0, 1));
                @(negedge clk);
                start = 1'b0;
            end
            wait_cyc(e0 + h * (2 * DW + 1) + 1 + $urandom_range(0, 3));
        end
        repeat (5) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
